// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared definitions for the pipeline stall/flush controller:
//            stall vector bit indices, stall encodings, FSM state codes and
//            the nop constants loaded into bubbled pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Bit positions inside the 6-bit hold vector
  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;
  localparam int STALL_WB    = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  // Decode stall: hold pc, if/id and id/ex; the id/ex input is bubbled
  localparam logic [5:0] STALL_ID   = 6'b000111;
  // Execute stall: additionally hold ex/mem; ex/mem input is bubbled
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } pc_state_t;

  // Nop payload that a bubbled id/ex register loads instead of decode outputs
  localparam logic [3:0]  exe_nop_op    = 4'h0;
  localparam logic [1:0]  exe_res_nop   = 2'b00;
  localparam logic [31:0] zero_word     = 32'h0000_0000;
  localparam logic [4:0]  nop_reg_addr  = 5'd0;
  localparam logic        write_disable = 1'b0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_perf
// Purpose  : 32-bit stall-cycle counter, wraps modulo 2^32, with a
//            synchronous clear that overrides the increment.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            inc             - count this cycle
//            clr             - load zero this cycle (wins over inc)
//            count[31:0]     - current count
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 32'd0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule : pipe_ctrl_perf
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush controller for the five-stage pipeline.
//            Arbitrates flush (highest), execute multi-cycle stall and
//            decode load-use stall; sequences multi-cycle execute ops and
//            counts stalled cycles.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            id_stall_req           - load-use hazard from decode
//            ex_mc_start/ex_mc_len  - start of a multi-cycle op and its length
//            flush_req              - redirect, kill younger stages
//            perf_clr               - clear stall_cycles
//            stall[5:0]             - hold vector (pc .. wb)
//            bubble_id_ex/ex_mem    - load nop into that register
//            flush                  - clear if/id, id/ex, ex/mem
//            mc_done                - last stall cycle of a multi-cycle op
//            mc_busy                - registered: FSM in MC_WAIT
//            stall_cycles[31:0]     - count of cycles with stall[0]=1
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6,
  parameter int MC_MAX   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stall_req,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                flush_req,
  input  logic                perf_clr,
  output logic [5:0]          stall,
  output logic                bubble_id_ex,
  output logic                bubble_ex_mem,
  output logic                flush,
  output logic                mc_done,
  output logic                mc_busy,
  output logic [31:0]         stall_cycles
);

  localparam logic [MC_LEN_W-1:0] C_MC_MAX = MC_LEN_W'(MC_MAX);

  pc_state_t             state, state_nxt;
  logic [MC_LEN_W-1:0]   cnt, cnt_nxt;
  logic [MC_LEN_W-1:0]   len_eff;

  // Oversized requests are clamped to the longest supported op
  assign len_eff = (ex_mc_len > C_MC_MAX) ? C_MC_MAX : ex_mc_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      mc_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mc_busy <= (state_nxt == ST_MC_WAIT);
    end
  end

  // cnt holds the number of MC_WAIT cycles left after the current one, so an
  // op of length L spends one cycle in RUN and L-1 cycles in MC_WAIT.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stall         = STALL_NONE;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    flush         = 1'b0;
    mc_done       = 1'b0;

    if (flush_req) begin
      flush     = 1'b1;
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else if (state == ST_MC_WAIT) begin
      stall         = STALL_EX;
      bubble_ex_mem = 1'b1;
      if (cnt == '0) begin
        mc_done   = 1'b1;
        state_nxt = ST_RUN;
      end else begin
        cnt_nxt = cnt - MC_LEN_W'(1);
      end
    end else if (ex_mc_start && (len_eff != '0)) begin
      stall         = STALL_EX;
      bubble_ex_mem = 1'b1;
      if (len_eff == MC_LEN_W'(1)) begin
        mc_done = 1'b1;
      end else begin
        cnt_nxt   = len_eff - MC_LEN_W'(2);
        state_nxt = ST_MC_WAIT;
      end
    end else if (id_stall_req) begin
      stall        = STALL_ID;
      bubble_id_ex = 1'b1;
    end
  end

  pipe_ctrl_perf u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[STALL_PC]),
    .clr   (perf_clr),
    .count (stall_cycles)
  );

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Scoreboard bench for pipe_ctrl. The driver applies one directed
//            vector per cycle and queues the hand-computed response; the
//            monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall_req = 1'b0;
  logic        ex_mc_start = 1'b0;
  logic [5:0]  ex_mc_len = 6'd0;
  logic        flush_req = 1'b0;
  logic        perf_clr = 1'b0;
  logic [5:0]  stall;
  logic        bubble_id_ex, bubble_ex_mem, flush, mc_done, mc_busy;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_LEN_W(6), .MC_MAX(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_stall_req  (id_stall_req),
    .ex_mc_start   (ex_mc_start),
    .ex_mc_len     (ex_mc_len),
    .flush_req     (flush_req),
    .perf_clr      (perf_clr),
    .stall         (stall),
    .bubble_id_ex  (bubble_id_ex),
    .bubble_ex_mem (bubble_ex_mem),
    .flush         (flush),
    .mc_done       (mc_done),
    .mc_busy       (mc_busy),
    .stall_cycles  (stall_cycles)
  );

  // {stall, bubble_id_ex, bubble_ex_mem, flush, mc_done, mc_busy}
  typedef struct packed {
    logic [10:0] flags;
    logic [31:0] sc;
    logic [7:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] sc_exp = 32'd0;
  logic [7:0]  tag = 8'd0;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  // One cycle: drive inputs just after the edge, queue the expected response.
  task automatic step(input logic r, input logic id, input logic st,
                      input logic [5:0] len, input logic fl, input logic pc,
                      input logic [5:0] es, input logic ebid, input logic ebex,
                      input logic efl, input logic edone, input logic ebusy);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_stall_req = id; ex_mc_start = st; ex_mc_len = len;
    flush_req = fl; perf_clr = pc;
    e.flags = {es, ebid, ebex, efl, edone, ebusy};
    e.sc    = sc_exp;
    e.tag   = tag;
    q.push_back(e);
    if (r || pc) sc_exp = 32'd0;
    else if (es[0]) sc_exp = sc_exp + 32'd1;
  endtask

  task automatic idle(input logic ebusy);
    step(0, 0, 0, 6'd0, 0, 0, S0, 0, 0, 0, 0, ebusy);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({stall, bubble_id_ex, bubble_ex_mem, flush, mc_done, mc_busy} !== e.flags) begin
        bad++;
        $display("FAIL ctl[%0d] got stall=%b bid=%b bex=%b fl=%b done=%b busy=%b want %b_%b%b%b%b%b",
                 e.tag, stall, bubble_id_ex, bubble_ex_mem, flush, mc_done, mc_busy,
                 e.flags[10:5], e.flags[4], e.flags[3], e.flags[2], e.flags[1], e.flags[0]);
      end
      total++;
      if (stall_cycles !== e.sc) begin
        bad++;
        $display("FAIL stall_cycles[%0d] got %h want %h", e.tag, stall_cycles, e.sc);
      end
    end
  end

  initial begin
    // reset
    tag = 1;  step(1, 0, 0, 6'd0, 0, 0, S0, 0, 0, 0, 0, 0);
              step(1, 0, 0, 6'd0, 0, 0, S0, 0, 0, 0, 0, 0);
              idle(0);
    // decode stall for two cycles
    tag = 2;  step(0, 1, 0, 6'd0, 0, 0, SI, 1, 0, 0, 0, 0);
              step(0, 1, 0, 6'd0, 0, 0, SI, 1, 0, 0, 0, 0);
              idle(0);
    // len=3
    tag = 3;  step(0, 0, 1, 6'd3, 0, 0, SE, 0, 1, 0, 0, 0);
              step(0, 0, 0, 6'd0, 0, 0, SE, 0, 1, 0, 0, 1);
              step(0, 0, 0, 6'd0, 0, 0, SE, 0, 1, 0, 1, 1);
              idle(0);
    // len=1 and len=0
    tag = 4;  step(0, 0, 1, 6'd1, 0, 0, SE, 0, 1, 0, 1, 0);
              idle(0);
    tag = 5;  step(0, 0, 1, 6'd0, 0, 0, S0, 0, 0, 0, 0, 0);
              idle(0);
    // len=40 clamps to 32
    tag = 6;
    for (int i = 0; i < 32; i++)
      step(0, 0, (i == 0), 6'd40, 0, 0, SE, 0, 1, 0, (i == 31), (i != 0));
    idle(0);
    // flush in cycle 1 of len=5
    tag = 7;  step(0, 0, 1, 6'd5, 0, 0, SE, 0, 1, 0, 0, 0);
              step(0, 0, 0, 6'd0, 1, 0, S0, 0, 0, 1, 0, 1);
              idle(0);
              idle(0);
    // flush together with start
    tag = 8;  step(0, 0, 1, 6'd4, 1, 0, S0, 0, 0, 1, 0, 0);
              idle(0);
    // execute stall beats decode stall
    tag = 9;  step(0, 1, 1, 6'd2, 0, 0, SE, 0, 1, 0, 0, 0);
              step(0, 1, 0, 6'd0, 0, 0, SE, 0, 1, 0, 1, 1);
              idle(0);
    // reset during MC_WAIT
    tag = 10; step(0, 0, 1, 6'd5, 0, 0, SE, 0, 1, 0, 0, 0);
              step(1, 0, 0, 6'd0, 0, 0, SE, 0, 1, 0, 0, 1);
              idle(0);
              idle(0);
    // back-to-back op accepted right after mc_done
    tag = 11; step(0, 0, 1, 6'd2, 0, 0, SE, 0, 1, 0, 0, 0);
              step(0, 0, 1, 6'd7, 0, 0, SE, 0, 1, 0, 1, 1);
              step(0, 0, 1, 6'd1, 0, 0, SE, 0, 1, 0, 1, 0);
              idle(0);
    // wrap: preload counter to all ones
    tag = 12;
    wait (q.size() == 0);
    @(posedge clk);
    #1;
    rst = 0; id_stall_req = 0; ex_mc_start = 0; flush_req = 0; perf_clr = 0;
    force dut.u_perf.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.count;
    sc_exp = 32'hFFFF_FFFF;
              step(0, 1, 0, 6'd0, 0, 0, SI, 1, 0, 0, 0, 0);
              step(0, 1, 0, 6'd0, 0, 0, SI, 1, 0, 0, 0, 0);
    // clear wins over a stall in the same cycle
    tag = 13; step(0, 1, 0, 6'd0, 0, 1, SI, 1, 0, 0, 0, 0);
              idle(0);
              idle(0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_ctrl
`default_nettype wire
